// File: rtl/mix_col_ctrl_pkg.sv
// Shared types for the mix_col sequencer.
//   state_e : controller FSM states
//   byte_t  : one state byte
//   col_t   : one 4-byte column, element 0 is the first byte on the wire
//   idx_t   : byte index within a column
package mix_col_ctrl_pkg;

  localparam int unsigned COL_BYTES = 4;
  localparam int unsigned IDX_W     = $clog2(COL_BYTES);

  typedef logic [7:0]                 byte_t;
  typedef byte_t [COL_BYTES-1:0]      col_t;
  typedef logic [IDX_W-1:0]           idx_t;

  localparam idx_t IDX_LAST = idx_t'(COL_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_FEED,
    ST_WAIT,
    ST_EMIT
  } state_e;

  function automatic logic is_last_byte(input idx_t idx);
    return idx == IDX_LAST;
  endfunction

endpackage

// File: rtl/mix_col_ctrl_col_buf.sv
// mc_col_buf: one column of byte storage.
//   clk, rst            : clock, synchronous active-high clear
//   wr_en/wr_idx/wr_data: single-byte indexed write
//   ld_en/ld_data       : whole-column load (wins over wr_en)
//   rd_idx/rd_data      : combinational indexed read
module mc_col_buf
  import mix_col_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic             ld_en,
  input  col_t             ld_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data
);

  col_t mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (ld_en) begin
      mem_d = ld_data;
    end else if (wr_en) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/mix_col_ctrl.sv
// mix_col_ctrl: sequencer for the byte-serial mix_col datapath.
// Collects a 4-byte column from the upstream stream, feeds it to mix_col as a
// gap-free 4-cycle burst, captures the column result and re-serialises it
// downstream. Bypass mode (final round) passes bytes through untouched.
//   clk, rst           : clock, synchronous active-high reset
//   start/mode/bypass  : block start; mode/bypass latched with start in IDLE
//   s_data/s_valid/s_ready : upstream byte stream
//   m_data/m_valid/m_ready : downstream byte stream
//   mc_d_in/mc_en/mc_mode  : drive to mix_col (registered)
//   mc_d0..mc_d3       : mix_col column result
//   busy               : block in progress
//   done               : one-cycle pulse after the last byte of the block leaves
module mix_col_ctrl
  import mix_col_ctrl_pkg::*;
#(
  parameter int unsigned NCOL   = 4,
  parameter int unsigned MC_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       bypass,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] mc_d_in,
  output logic       mc_en,
  output logic       mc_mode,
  input  logic [7:0] mc_d0,
  input  logic [7:0] mc_d1,
  input  logic [7:0] mc_d2,
  input  logic [7:0] mc_d3,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int unsigned LW = $clog2(MC_LAT + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(NCOL - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(MC_LAT - 1);

  state_e        state_q, state_d;
  idx_t          byte_cnt_q, byte_cnt_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic          bypass_q, bypass_d;
  logic          mc_mode_q, mc_mode_d;
  logic          mc_en_q, mc_en_d;
  byte_t         mc_d_in_q, mc_d_in_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          s_fire, m_fire;
  idx_t          in_rd_idx;
  byte_t         in_rd_data;
  logic          out_wr_en, out_ld_en;
  byte_t         out_rd_data;
  col_t          mc_col;

  // Handshakes derived straight from the state register so the next-state
  // and output processes do not depend on each other.
  assign s_fire = s_valid && (state_q == ST_COLLECT);
  assign m_fire = m_ready && (state_q == ST_EMIT);
  assign mc_col = {mc_d3, mc_d2, mc_d1, mc_d0};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      col_cnt_q  <= '0;
      lat_cnt_q  <= '0;
      bypass_q   <= 1'b0;
      mc_mode_q  <= 1'b0;
      mc_en_q    <= 1'b0;
      mc_d_in_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      col_cnt_q  <= col_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      bypass_q   <= bypass_d;
      mc_mode_q  <= mc_mode_d;
      mc_en_q    <= mc_en_d;
      mc_d_in_q  <= mc_d_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and counters. byte_cnt wraps to 0 after byte 3, which is
  // exactly the starting index for the following FEED or EMIT phase.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    col_cnt_d  = col_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    bypass_d   = bypass_q;
    mc_mode_d  = mc_mode_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mc_mode_d  = mode;
          bypass_d   = bypass;
          col_cnt_d  = '0;
          byte_cnt_d = '0;
          state_d    = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (s_fire) begin
          byte_cnt_d = byte_cnt_q + idx_t'(1);
          if (is_last_byte(byte_cnt_q)) begin
            state_d = bypass_q ? ST_EMIT : ST_FEED;
          end
        end
      end
      ST_FEED: begin
        byte_cnt_d = byte_cnt_q + idx_t'(1);
        if (is_last_byte(byte_cnt_q)) begin
          lat_cnt_d = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          state_d = ST_EMIT;
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end
      ST_EMIT: begin
        if (m_fire) begin
          byte_cnt_d = byte_cnt_q + idx_t'(1);
          if (is_last_byte(byte_cnt_q)) begin
            if (col_cnt_q == COL_LAST) begin
              state_d = ST_IDLE;
            end else begin
              col_cnt_d = col_cnt_q + CW'(1);
              state_d   = ST_COLLECT;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and buffer control
  always_comb begin
    s_ready   = (state_q == ST_COLLECT);
    m_valid   = (state_q == ST_EMIT);
    m_data    = out_rd_data;
    in_rd_idx = byte_cnt_d;
    // Bypass fills out_buf byte by byte alongside in_buf, so it already
    // equals in_buf once the column's last byte has arrived.
    out_wr_en = s_fire && bypass_q;
    out_ld_en = (state_q == ST_WAIT) && (lat_cnt_q == LAT_LAST);
    // mc_en/mc_d_in are registered from the next state so each FEED cycle
    // carries its own byte on the mix_col inputs.
    mc_en_d   = 1'b0;
    mc_d_in_d = mc_d_in_q;
    if (state_d == ST_FEED) begin
      mc_en_d   = (byte_cnt_d != '0);
      mc_d_in_d = in_rd_data;
    end
    busy_d = (state_d != ST_IDLE);
    done_d = m_fire && is_last_byte(byte_cnt_q) && (col_cnt_q == COL_LAST);
  end

  mc_col_buf u_in_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s_fire),
    .wr_idx  (byte_cnt_q),
    .wr_data (s_data),
    .ld_en   (1'b0),
    .ld_data ('0),
    .rd_idx  (in_rd_idx),
    .rd_data (in_rd_data)
  );

  mc_col_buf u_out_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (out_wr_en),
    .wr_idx  (byte_cnt_q),
    .wr_data (s_data),
    .ld_en   (out_ld_en),
    .ld_data (mc_col),
    .rd_idx  (byte_cnt_q),
    .rd_data (out_rd_data)
  );

  assign mc_d_in = mc_d_in_q;
  assign mc_en   = mc_en_q;
  assign mc_mode = mc_mode_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mix_col_ctrl.sv
// Bench for mix_col_ctrl with a behavioural byte-serial mix_col alongside it.
module tb_mix_col_ctrl;

  localparam int unsigned NCOL   = 4;
  localparam int unsigned MC_LAT = 1;
  localparam int unsigned BLK    = 4 * NCOL;

  logic       clk = 1'b0;
  logic       rst, start, mode, bypass;
  logic [7:0] s_data;
  logic       s_valid, s_ready;
  logic [7:0] m_data;
  logic       m_valid, m_ready;
  logic [7:0] mc_d_in;
  logic       mc_en, mc_mode;
  logic [7:0] mc_d0 = '0, mc_d1 = '0, mc_d2 = '0, mc_d3 = '0;
  logic       busy, done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mix_col_ctrl #(.NCOL(NCOL), .MC_LAT(MC_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .bypass(bypass),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .mc_d_in(mc_d_in), .mc_en(mc_en), .mc_mode(mc_mode),
    .mc_d0(mc_d0), .mc_d1(mc_d1), .mc_d2(mc_d2), .mc_d3(mc_d3),
    .busy(busy), .done(done)
  );

  // ---------------- GF(2^8) MixColumns reference ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = xt(x);
    end
    return r;
  endfunction

  // col = {b0,b1,b2,b3}; circulant matrix with first row k[0..3]
  function automatic logic [31:0] mixcol(input logic [31:0] col, input logic fwd);
    logic [7:0]  a [4];
    logic [7:0]  k [4];
    logic [7:0]  d;
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
    if (fwd) k = '{8'h02, 8'h03, 8'h01, 8'h01};
    else     k = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int r = 0; r < 4; r++) begin
      d = '0;
      for (int c = 0; c < 4; c++) d ^= gm(k[(c + 4 - r) % 4], a[c]);
      res[31-8*r -: 8] = d;
    end
    return res;
  endfunction

  // ---------------- behavioural mix_col (byte-serial, 1-cycle latency) ----
  logic [7:0] mcb [3];
  int         mcn = 0;
  always @(posedge clk) begin
    if (rst) begin
      mcn <= 0;
    end else if (!mc_en) begin
      mcb[0] <= mc_d_in;
      mcn    <= 1;
    end else begin
      if (mcn >= 1 && mcn < 3) mcb[mcn] <= mc_d_in;
      if (mcn < 4) mcn <= mcn + 1;
      if (mcn == 3)
        {mc_d0, mc_d1, mc_d2, mc_d3} <= mixcol({mcb[0], mcb[1], mcb[2], mc_d_in}, mc_mode);
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_s_ready"}, 32'(s_ready), 0);
    chk({nm, "_m_valid"}, 32'(m_valid), 0);
    chk({nm, "_m_data"},  32'(m_data),  0);
    chk({nm, "_mc_d_in"}, 32'(mc_d_in), 0);
    chk({nm, "_mc_en"},   32'(mc_en),   0);
    chk({nm, "_mc_mode"}, 32'(mc_mode), 0);
    chk({nm, "_busy"},    32'(busy),    0);
    chk({nm, "_done"},    32'(done),    0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [7:0] exp_q [$];
  logic [7:0] got   [$];
  logic [7:0] mon_exp, prev_data;
  int  acc_cnt = 0, done_seen = 0, en_run = 0, feeds = 0;
  bit  done_pend = 0, prev_stall = 0, mon_on = 0;
  bit  blk_bypass = 0, blk_mode = 0, abort = 0;

  always @(negedge clk) begin
    if (rst) begin
      acc_cnt = 0; done_pend = 0; en_run = 0; prev_stall = 0;
    end else if (mon_on) begin
      chk("done", 32'(done), 32'(done_pend));
      done_pend = 0;
      if (done) begin
        done_seen++;
        chk("busy_at_done", 32'(busy), 0);
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 1);
        chk("stall_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("m_extra_byte", 32'(m_data), 32'hffff_ffff);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("m_data", 32'(m_data), 32'(mon_exp));
        end
        got.push_back(m_data);
        acc_cnt++;
        if (acc_cnt == BLK) begin
          done_pend = 1;
          acc_cnt   = 0;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (blk_bypass) chk("bypass_mc_en", 32'(mc_en), 0);
      if (mc_en === 1'b1) begin
        en_run++;
      end else begin
        if (en_run != 0) begin
          chk("feed_run_len", 32'(en_run), 3);
          if (en_run == 3) feeds++;
        end
        en_run = 0;
      end
      if (busy) chk("mc_mode_hold", 32'(mc_mode), 32'(blk_mode));
    end
  end

  // ---------------- stimulus ----------------
  task automatic src(input logic [7:0] data [BLK], input int gap);
    int idx   = 0;
    int guard = 0;
    bit acc;
    while (idx < BLK && !abort && guard < 4000) begin
      s_valid = ($urandom_range(99) >= gap);
      s_data  = s_valid ? data[idx] : 8'($urandom);
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      guard++;
      if (acc) idx++;
    end
    s_valid = 1'b0;
    if (!abort && idx < BLK) chk("src_timeout", 32'(idx), 32'(BLK));
  endtask

  task automatic snk(input int stall, input int abort_at);
    int guard = 0;
    while (got.size() < BLK && !abort && guard < 4000) begin
      m_ready = ($urandom_range(99) >= stall);
      start   = (got.size() + 2 <= BLK) && ($urandom_range(15) == 0);
      mode    = 1'($urandom);
      bypass  = 1'($urandom);
      @(posedge clk); #1;
      guard++;
      if (abort_at >= 0 && got.size() >= abort_at) begin
        abort   = 1;
        rst     = 1'b1;
        m_ready = 1'b0;
      end
    end
    start   = 1'b0;
    m_ready = 1'b0;
    if (!abort && got.size() < BLK) chk("snk_timeout", 32'(got.size()), 32'(BLK));
  endtask

  task automatic run_block(input bit md, input bit byp, input logic [7:0] data [BLK],
                           input int gap, input int stall, input int abort_at);
    logic [31:0] col, r;
    exp_q.delete();
    got.delete();
    for (int c = 0; c < NCOL; c++) begin
      col = {data[4*c], data[4*c+1], data[4*c+2], data[4*c+3]};
      r   = byp ? col : mixcol(col, md);
      for (int b = 0; b < 4; b++) exp_q.push_back(r[31-8*b -: 8]);
    end
    blk_mode = md; blk_bypass = byp; done_seen = 0; feeds = 0;
    @(posedge clk); #1;
    start = 1'b1; mode = md; bypass = byp;
    @(posedge clk); #1;
    start = 1'b0; mode = ~md; bypass = ~byp;
    fork
      src(data, gap);
      snk(stall, abort_at);
    join
    if (abort) begin
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_zero("post_rst");
      chk("abort_no_done", 32'(done_seen), 0);
      exp_q.delete();
      abort = 0;
    end else begin
      repeat (3) @(negedge clk);
      chk("done_count", 32'(done_seen), 1);
      chk("busy_after", 32'(busy), 0);
      chk("exp_left", 32'(exp_q.size()), 0);
      chk("feed_bursts", 32'(feeds), byp ? 0 : NCOL);
    end
    blk_bypass = 0;
  endtask

  task automatic fill(output logic [7:0] d [BLK], input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] w [4];
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < BLK; i++) d[i] = w[i/4][31-8*(i%4) -: 8];
  endtask

  task automatic chk_got(input string nm, input int ncols, input logic [31:0] w0,
                         input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] w [4];
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < 4*ncols; i++) begin
      if (i < got.size()) chk(nm, 32'(got[i]), 32'(w[i/4][31-8*(i%4) -: 8]));
      else                chk({nm, "_missing"}, 32'(got.size()), 32'(i + 1));
    end
  endtask

  logic [7:0] d [BLK];

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; bypass = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    mon_on = 1;

    // 1: forward, first column db135345
    fill(d, 32'hdb135345, $urandom, $urandom, $urandom);
    run_block(1'b1, 1'b0, d, 0, 0, -1);
    chk_got("t1_fwd", 1, 32'h8e4da1bc, 0, 0, 0);

    // 2: inverse undoes it
    fill(d, 32'h8e4da1bc, $urandom, $urandom, $urandom);
    run_block(1'b0, 1'b0, d, 0, 0, -1);
    chk_got("t2_inv", 1, 32'hdb135345, 0, 0, 0);

    // 3: forward, four known columns
    fill(d, 32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
    run_block(1'b1, 1'b0, d, 0, 0, -1);
    chk_got("t3_fwd4", 4, 32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6);

    // 4: bypass
    for (int i = 0; i < BLK; i++) d[i] = 8'(i);
    run_block(1'b1, 1'b1, d, 0, 0, -1);
    chk_got("t4_byp", 4, 32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f);

    // 5: case 3 under random gaps and back-pressure
    fill(d, 32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
    run_block(1'b1, 1'b0, d, 40, 50, -1);
    chk_got("t5_bp", 4, 32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6);

    // 6: reset during EMIT of column 2, then restart
    run_block(1'b1, 1'b0, d, 20, 20, 9);
    fill(d, 32'hdb135345, $urandom, $urandom, $urandom);
    run_block(1'b1, 1'b0, d, 10, 10, -1);
    chk_got("t6_restart", 1, 32'h8e4da1bc, 0, 0, 0);

    // random blocks
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < BLK; i++) d[i] = 8'($urandom);
      run_block(1'($urandom), 1'($urandom_range(3) == 0), d, 30, 30, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
